// File: rtl/sd_dac_out.sv
// Multi-channel audio DAC output stage: frame FIFO, sample-rate pop, 1st-order sigma-delta per channel.
// Latency: frame reaches cur at the first sample_tick after push; dac_out follows one clk later.
// Backpressure: in_ready drops when the FIFO holds FIFO_DEPTH frames; underrun pulses on an empty-FIFO tick.
// Optional simulation logging: define DAC_LOG_EN.
module sd_dac_out #(
    parameter int WIDTH      = 4,
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_DIV = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [CHANNELS-1:0]           dac_out
);
    localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = CHANNELS * WIDTH;

    logic [DW-1:0]  div;
    logic [FW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [FW-1:0]  cur;
    // Only the low WIDTH bits of each accumulator persist; the carry is held in dac_out.
    logic [WIDTH-1:0] acc [CHANNELS];
    logic [WIDTH:0]   sum [CHANNELS];
    logic           push;
    logic           pop;

    assign in_ready = (fifo_level < LW'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = sample_tick & (fifo_level != '0);
    // An empty FIFO at the tick leaves cur holding the previous frame.
    assign underrun = sample_tick & (fifo_level == '0);

    // Sample-period divider; tick is registered so it lands the cycle after the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (div == DW'(SAMPLE_DIV - 1));
            if (div == DW'(SAMPLE_DIV - 1))
                div <= '0;
            else
                div <= div + 1'b1;
        end
    end

    // Frame storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Current frame: loaded from the FIFO head on a tick, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur <= '0;
        else if (pop)
            cur <= mem[rd_ptr];
    end

    // Per-channel accumulator sum; the carry out is the 1-bit modulator output.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            sum[c] = {1'b0, acc[c]} + {1'b0, cur[c*WIDTH +: WIDTH]};
    end

    // Sigma-delta state update, every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++)
                acc[c] <= '0;
            dac_out <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]     <= sum[c][WIDTH-1:0];
                dac_out[c] <= sum[c][WIDTH];
            end
        end
    end

`ifdef DAC_LOG_EN
    function automatic string cur_str();
        string s;
        s = "";
        for (int c = 0; c < CHANNELS; c++)
            s = {s, $sformatf(" %0d", cur[c*WIDTH +: WIDTH])};
        return s;
    endfunction

    initial $display("%0d %0d %0d", WIDTH, CHANNELS, SAMPLE_DIV);

    // Tick log: $strobe defers evaluation so cur shows the post-pop frame.
    always @(posedge clk) begin
        if (rst_n && sample_tick) begin
            if (underrun)
                $display("%0t UNDERRUN", $time);
            $strobe("%0t%s", $time, cur_str());
        end
    end
`endif

endmodule

// File: tb/tb_sd_dac_out.sv
module tb_sd_dac_out;
    localparam int W   = 4;
    localparam int CH  = 2;
    localparam int DIV = 16;
    localparam int DEP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   fifo_level;
    logic         sample_tick;
    logic         underrun;
    logic [1:0]   dac_out;

    int n_assert = 0;
    int n_fail   = 0;

    sd_dac_out #(.WIDTH(W), .CHANNELS(CH), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .fifo_level(fifo_level), .sample_tick(sample_tick),
        .underrun(underrun), .dac_out(dac_out)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: queue of frames, tick every DIV clocks since release,
    // each channel produces carries of a modulo-16 running sum of its sample.
    logic [7:0] q[$];
    int         cnt = 0;
    bit         m_tick = 0;
    int         cur_m [CH] = '{0, 0};
    int         acc_m [CH] = '{0, 0};
    logic [1:0] m_dac = '0;
    logic [7:0] f;
    bit         m_push, m_pop;
    int         s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cnt = 0;
            m_tick = 0;
            m_dac = '0;
            for (int c = 0; c < CH; c++) begin
                cur_m[c] = 0;
                acc_m[c] = 0;
            end
        end else begin
            m_push = in_valid && (q.size() < DEP);
            m_pop  = m_tick && (q.size() > 0);
            for (int c = 0; c < CH; c++) begin
                s = acc_m[c] + cur_m[c];
                m_dac[c] = (s >= 16);
                acc_m[c] = s % 16;
            end
            if (m_pop) begin
                f = q.pop_front();
                cur_m[0] = int'(f[3:0]);
                cur_m[1] = int'(f[7:4]);
            end
            if (m_push)
                q.push_back(in_data);
            cnt++;
            m_tick = (cnt % DIV == 0);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_level",    int'(fifo_level),  q.size());
        chk("m_in_ready", int'(in_ready),    int'(q.size() < DEP));
        chk("m_tick",     int'(sample_tick), int'(m_tick));
        chk("m_underrun", int'(underrun),    int'(m_tick && q.size() == 0));
        chk("m_dac",      int'(dac_out),     int'(m_dac));
    end

    task automatic push_frame(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 100);
        if (!sample_tick) chk("tick_timeout", n, 0);
    endtask

    // Counts ones on each channel over 16 consecutive samples starting now.
    task automatic window(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            c0 += int'(dac_out[0]);
            c1 += int'(dac_out[1]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, n;
        // 1. reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_data  = 8'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_dac",   int'(dac_out), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_tick",  int'(sample_tick), 0);
        chk("rst_under", int'(underrun), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk("rel_in_ready", int'(in_ready), 1);

        // 2. five back-to-back pushes before the first tick
        push_frame(8'h08); chk("lvl1", int'(fifo_level), 1);
        push_frame(8'hF1); chk("lvl2", int'(fifo_level), 2);
        push_frame(8'h35); chk("lvl3", int'(fifo_level), 3);
        push_frame(8'h7A); chk("lvl4", int'(fifo_level), 4);
        in_valid = 1'b1;
        in_data  = 8'hC2;
        @(negedge clk);
        chk("full_stall", int'(in_ready), 0);
        wait_tick();
        chk("tick1_lvl", int'(fifo_level), 4);
        chk("tick1_rdy", int'(in_ready), 0);
        @(negedge clk);
        chk("pop1_lvl", int'(fifo_level), 3);
        chk("pop1_rdy", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("push5_lvl", int'(fifo_level), 4);

        // 3. frame {ch1=0, ch0=8}
        window(c0, c1);
        chk("f08_ch0", c0, 8);
        chk("f08_ch1", c1, 0);

        // 4. frame {ch1=15, ch0=1}
        @(negedge clk);
        window(c0, c1);
        chk("fF1_ch0", c0, 1);
        chk("fF1_ch1", c1, 15);

        // 5. drain to empty; push during the underrun tick
        wait_tick();
        wait_tick();
        wait_tick();
        chk("ur_pulse", int'(underrun), 1);
        chk("ur_lvl0",  int'(fifo_level), 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ur_clear", int'(underrun), 0);
        chk("ur_lvl1",  int'(fifo_level), 1);
        @(negedge clk);
        window(c0, c1);
        chk("hold_ch0", c0, 2);
        chk("hold_ch1", c1, 12);

        // 6. asynchronous reset mid-period with three frames queued
        push_frame(8'h11);
        push_frame(8'h22);
        push_frame(8'h33);
        chk("pre_rst_lvl", int'(fifo_level), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dac",   int'(dac_out), 0);
        chk("arst_level", int'(fifo_level), 0);
        chk("arst_tick",  int'(sample_tick), 0);
        chk("arst_under", int'(underrun), 0);
        chk("arst_rdy",   int'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 40);
        chk("rel_tick_delay", n, 16);
        chk("rel_tick_under", int'(underrun), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
